hs4_rx_fifo: RTL

Clocked receive stage that sits directly downstream of the asynchronous four-phase pipeline stage (`stage3`) and consumes its `req_out`/`data_out` bundle. It synchronises the incoming request and completes the four-phase handshake. Each accepted word is buffered in a small FIFO and presented on a synchronous valid/ready stream to the clocked logic behind it. Back-pressure from the stream stalls the handshake, never drops data.

---
 rtl/hs4_rx_fifo.sv | 101 ++++++++++
 1 files changed

// File: rtl/hs4_rx_fifo.sv
// Clocked receiver for a four-phase bundled-data request: synchronises req_in, acknowledges,
// and buffers each accepted word in a small FIFO drained over a valid/ready stream.
module hs4_rx_fifo #(
   parameter int unsigned WIDTH       = 3,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_in,
   input  logic [WIDTH-1:0]           data_in,
   output logic                       ack_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   typedef enum logic [0:0] {StIdle, StAck} state_e;

   state_e               state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        level_q, level_d;
   logic [WIDTH-1:0]     mem_q [DEPTH];

   logic req_s;
   logic full;
   logic push;
   logic pop;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], req_in};
   assign req_s  = sync_q[SYNC_STAGES-1];
   assign full   = (level_q == LW'(DEPTH));
   assign pop    = out_valid && out_ready;

   // State register, synchroniser and FIFO bookkeeping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         sync_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (req_s && !full) state_d = StAck;
         StAck:   if (!req_s) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      push   = 1'b0;
      ack_in = 1'b0;
      unique case (state_q)
         StIdle:  push = req_s && !full;
         StAck:   ack_in = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   assign out_valid = (level_q != '0);
   assign out_data  = mem_q[rd_ptr_q];
   assign level     = level_q;

endmodule
